bayer_binarizer: RTL and testbench
==================================

Name: bayer_binarizer

Overview:
Parametrised successor to the skin/background binariser in the IPU camera path. It takes raw Bayer samples from the CCD capture stage and bins each 2x2 block into one grey value using an internal line buffer. Each grey value is classified against a runtime-programmable band, with selectable polarity. A per-frame foreground pixel count is reported to the gesture logic downstream.

Parameters:
DATA_W, 12, raw sample width and grey output width
LINE_W, 640, raw pixels per line (line-buffer depth)
CNT_W, 20, width of the foreground counter

Ports:
iCLK  in  1  clock
iRST  in  1  reset, synchronous, active-high
iDATA  in  DATA_W  raw Bayer sample
iDVAL  in  1  iDATA valid
iX_Cont  in  16  column of current sample
iY_Cont  in  16  row of current sample
iSOF  in  1  one-cycle start-of-frame pulse, precedes the first pixel
iThr_Lo  in  DATA_W  band lower bound, inclusive
iThr_Hi  in  DATA_W  band upper bound, inclusive
iInvert  in  1  polarity select
oGrey  out  DATA_W  binned grey value
oBinary  out  1  classification bit
oDVAL  out  1  oGrey/oBinary valid
oFG_Count  out  CNT_W  foreground count of the last completed frame
oFrame_Done  out  1  one-cycle pulse when oFG_Count updates

Behaviour:
- Reset (iRST=1 at a rising edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Pipeline valids, shadow thresholds and the line-buffer pointer clear.
  - Line-buffer RAM contents are not cleared.
- Line buffer:
  - Depth LINE_W; read-before-write.
  - Advances only on iDVAL=1. Pointer wraps LINE_W-1 -> 0 and resets to 0 on iSOF.
  - Tap = sample from the same column, previous line. cur_d / tap_d = previous accepted iDATA / tap.
- Stage 1, on iDVAL=1:
  - sum = iDATA + tap + cur_d + tap_d, width DATA_W+2, no overflow.
  - v1 = iDVAL & iX_Cont[0] & iY_Cont[0], i.e. the bottom-right of each 2x2 block completes it.
- Stage 2:
  - oGrey <= sum[DATA_W+1:2] (truncating divide by 4).
  - oBinary <= in_band ? iInvert : ~iInvert, where in_band = (grey >= thr_lo) && (grey <= thr_hi).
  - oDVAL <= v1.
- Latency: exactly 2 cycles from a qualifying input to oDVAL. oGrey and oBinary hold their values while oDVAL=0.
- iInvert=0 is the legacy convention: band -> 0 (background), outside -> 1 (skin).
- Thresholds and iInvert are shadowed on iSOF and on the first cycle after reset. Mid-frame changes take effect at the next frame only.
- If thr_lo > thr_hi, the band is empty and every pixel gets ~iInvert.
- FSM:
  - IDLE: ignore counting; iSOF -> COUNT, running := 0.
  - COUNT: running increments when oDVAL & oBinary, saturating at 2^CNT_W-1.
  - COUNT with iSOF: oFG_Count <= running, including any increment in the same cycle. oFrame_Done=1 for one cycle. running := 0. Stay in COUNT.
- Pixels still in the pipeline at iSOF are counted in the new frame.
- iSOF coincident with iDVAL: the pointer reset applies first, and that sample is written at column 0.
- Back-to-back iSOF pulses report 0 for the empty frame.
- Reset mid-frame: discard all pipeline data, FSM -> IDLE, oFG_Count -> 0, no oFrame_Done.

Test Plan:
- Threshold band 205/255, iInvert=0, 4x4 frame (LINE_W=4), all samples 820 -> 4 oDVAL pulses, oGrey=820, oBinary=1. Next iSOF -> oFG_Count=4, oFrame_Done pulse.
- One block of 200, 240, 220, 260, band 205/255 -> oGrey=230, oBinary=0, exactly 2 cycles after the (1,1) sample. Same block with iInvert=1 -> oBinary=1.
- Boundaries, band 205/255: grey 204 -> 1; grey 205 -> 0; grey 255 -> 0; grey 256 -> 1. Thr_Lo=300, Thr_Hi=100 -> all 1.
- iDVAL toggling 1/0 every cycle across a line -> identical oGrey sequence to the continuous case. Pointer wraps correctly over 3 lines.
- Thr_Hi changed mid-frame -> classification unchanged until the next iSOF. CNT_W=3 with 10 foreground blocks -> oFG_Count=7.
- iRST asserted mid-frame for 1 cycle -> next cycle all outputs 0 and no oFrame_Done. A subsequent full frame counts correctly from 0.

Source files
------------

// File: rtl/bayer_binarizer.sv
// 2x2 Bayer binning with band classification and per-frame foreground count.
// A line buffer pairs each sample with the sample above it in the previous line.
module bayer_binarizer #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int CNT_W  = 20
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [15:0]       iX_Cont,
  input  logic [15:0]       iY_Cont,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iThr_Lo,
  input  logic [DATA_W-1:0] iThr_Hi,
  input  logic              iInvert,
  output logic [DATA_W-1:0] oGrey,
  output logic              oBinary,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oFG_Count,
  output logic              oFrame_Done
);

  localparam int PW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [PW-1:0] LAST = PW'(LINE_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  logic [DATA_W-1:0] lineMem [LINE_W];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     wPtr;
  logic [DATA_W-1:0] tap;
  logic [DATA_W-1:0] curD;
  logic [DATA_W-1:0] tapD;
  logic [DATA_W+1:0] sum;
  logic              v1;
  logic [DATA_W-1:0] grey;
  logic              inBand;
  logic              firstCyc;
  logic [DATA_W-1:0] thrLo;
  logic [DATA_W-1:0] thrHi;
  logic              inv;
  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  running;
  logic [CNT_W-1:0]  runInc;
  logic [CNT_W-1:0]  runNext;
  logic [CNT_W-1:0]  cntNext;
  logic              doneNext;
  logic              unusedBits;

  assign unusedBits = ^{iX_Cont[15:1], iY_Cont[15:1]};

  // SOF forces column 0 so a coincident sample lands at the line start
  assign wPtr = iSOF ? '0 : ptr;
  assign tap  = lineMem[wPtr];

  always_ff @(posedge iCLK) begin
    if (iDVAL) lineMem[wPtr] <= iDATA;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr <= '0;
    end else if (iDVAL) begin
      ptr <= (wPtr == LAST) ? '0 : wPtr + 1'b1;
    end else if (iSOF) begin
      ptr <= '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v1   <= 1'b0;
      sum  <= '0;
      curD <= '0;
      tapD <= '0;
    end else begin
      v1 <= iDVAL & iX_Cont[0] & iY_Cont[0];
      if (iDVAL) begin
        sum  <= {2'b00, iDATA} + {2'b00, tap}
              + {2'b00, curD} + {2'b00, tapD};
        curD <= iDATA;
        tapD <= tap;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      firstCyc <= 1'b1;
      thrLo    <= '0;
      thrHi    <= '0;
      inv      <= 1'b0;
    end else begin
      firstCyc <= 1'b0;
      if (firstCyc || iSOF) begin
        thrLo <= iThr_Lo;
        thrHi <= iThr_Hi;
        inv   <= iInvert;
      end
    end
  end

  assign grey   = sum[DATA_W+1:2];
  assign inBand = (grey >= thrLo) && (grey <= thrHi);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL   <= 1'b0;
      oGrey   <= '0;
      oBinary <= 1'b0;
    end else begin
      oDVAL <= v1;
      if (v1) begin
        oGrey   <= grey;
        oBinary <= inBand ? inv : ~inv;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iSOF) stateNext = COUNT;
      COUNT:   stateNext = COUNT;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    runInc   = running;
    runNext  = running;
    cntNext  = oFG_Count;
    doneNext = 1'b0;
    if (oDVAL && oBinary && running != CMAX) runInc = running + 1'b1;
    unique case (state)
      IDLE: begin
        if (iSOF) runNext = '0;
      end
      COUNT: begin
        runNext = runInc;
        if (iSOF) begin
          cntNext  = runInc;
          doneNext = 1'b1;
          runNext  = '0;
        end
      end
      default: runNext = '0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      running     <= '0;
      oFG_Count   <= '0;
      oFrame_Done <= 1'b0;
    end else begin
      running     <= runNext;
      oFG_Count   <= cntNext;
      oFrame_Done <= doneNext;
    end
  end

endmodule

// File: tb/tb_bayer_binarizer.sv
// Directed bench for bayer_binarizer on a 4x4 frame with a 3-bit counter.
// Outputs are captured on the falling edge and checked against fixed tables.
module tb_bayer_binarizer;

  typedef int frame_t [16];
  typedef int quad_t [4];

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic [15:0] iX_Cont;
  logic [15:0] iY_Cont;
  logic        iSOF;
  logic [11:0] iThr_Lo;
  logic [11:0] iThr_Hi;
  logic        iInvert;
  logic [11:0] oGrey;
  logic        oBinary;
  logic        oDVAL;
  logic [2:0]  oFG_Count;
  logic        oFrame_Done;

  bayer_binarizer #(.DATA_W(12), .LINE_W(4), .CNT_W(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iSOF(iSOF),
    .iThr_Lo(iThr_Lo), .iThr_Hi(iThr_Hi), .iInvert(iInvert),
    .oGrey(oGrey), .oBinary(oBinary), .oDVAL(oDVAL),
    .oFG_Count(oFG_Count), .oFrame_Done(oFrame_Done)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  int gq[$];
  int bq[$];
  int tq[$];
  int doneCnt = 0;
  int doneVal = 0;
  int t11 = 0;
  int total = 0;
  int passed = 0;
  int fails = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (oDVAL) begin
      gq.push_back(int'(oGrey));
      bq.push_back(int'(oBinary));
      tq.push_back(cyc);
    end
    if (oFrame_Done) begin
      doneCnt++;
      doneVal = int'(oFG_Count);
    end
  end

  task automatic chk(string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clr();
    gq.delete();
    bq.delete();
    tq.delete();
  endtask

  task automatic pix(input int x, input int y, input int d);
    iDATA   = 12'(d);
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    iDVAL   = 1'b1;
    if (x == 1 && y == 1) t11 = cyc;
    step();
    iDVAL = 1'b0;
  endtask

  task automatic frame(input frame_t px, input int y0, input int y1,
                       input bit gap);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 4; x++) begin
        pix(x, y, px[y*4+x]);
        if (gap) step();
      end
    repeat (3) step();
  endtask

  function automatic frame_t blk(input int a, input int b,
                                 input int c, input int d);
    frame_t f;
    quad_t q;
    q = '{a, b, c, d};
    for (int i = 0; i < 16; i++)
      f[i] = q[((i / 8) * 2) + ((i % 4) / 2)];
    return f;
  endfunction

  task automatic expOut(string tag, input quad_t eg, input quad_t eb);
    chk({tag, " count"}, gq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s grey%0d", tag, i),
          (i < gq.size()) ? gq[i] : -1, eg[i]);
      chk($sformatf("%s bin%0d", tag, i),
          (i < bq.size()) ? bq[i] : -1, eb[i]);
    end
    clr();
  endtask

  task automatic sofChk(string tag, input int exp);
    int d0;
    d0 = doneCnt;
    iSOF = 1'b1;
    step();
    iSOF = 1'b0;
    step();
    chk({tag, " done pulses"}, doneCnt - d0, 1);
    chk({tag, " fg count"}, doneVal, exp);
  endtask

  initial begin
    frame_t f;
    frame_t ramp;
    int d0;
    iRST = 1'b1; iDATA = '0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
    iSOF = 1'b0; iThr_Lo = 12'd205; iThr_Hi = 12'd255; iInvert = 1'b0;
    step();
    step();
    chk("rst grey", oGrey, 0);
    chk("rst bin", oBinary, 0);
    chk("rst dval", oDVAL, 0);
    chk("rst cnt", oFG_Count, 0);
    chk("rst done", oFrame_Done, 0);
    iRST = 1'b0;
    step();

    // first SOF only arms the counter
    d0 = doneCnt;
    iSOF = 1'b1; step(); iSOF = 1'b0; step();
    chk("idle sof no done", doneCnt - d0, 0);

    clr();
    frame(blk(820, 820, 820, 820), 0, 3, 1'b0);
    expOut("const820", '{820, 820, 820, 820}, '{1, 1, 1, 1});
    sofChk("const820", 4);

    f = '{200, 240, 200, 240, 220, 260, 220, 260,
          200, 240, 200, 240, 220, 260, 220, 260};
    clr();
    frame(f, 0, 3, 1'b0);
    chk("latency", (tq.size() > 0) ? tq[0] - t11 : -1, 2);
    expOut("blk230", '{230, 230, 230, 230}, '{0, 0, 0, 0});
    iInvert = 1'b1;
    sofChk("blk230", 0);
    frame(f, 0, 3, 1'b0);
    expOut("blk230inv", '{230, 230, 230, 230}, '{1, 1, 1, 1});
    iInvert = 1'b0;
    sofChk("blk230inv", 4);

    frame(blk(204, 205, 255, 256), 0, 3, 1'b0);
    expOut("bounds", '{204, 205, 255, 256}, '{1, 0, 0, 1});
    iThr_Lo = 12'd300; iThr_Hi = 12'd100;
    sofChk("bounds", 2);
    frame(blk(204, 205, 255, 256), 0, 3, 1'b0);
    expOut("empty band", '{204, 205, 255, 256}, '{1, 1, 1, 1});
    iThr_Lo = 12'd205; iThr_Hi = 12'd255;
    sofChk("empty band", 4);

    for (int i = 0; i < 16; i++) ramp[i] = 100 + 10 * i;
    ramp[5] = 153;
    frame(ramp, 0, 3, 1'b0);
    expOut("ramp", '{125, 145, 205, 225}, '{1, 1, 0, 0});
    sofChk("ramp", 2);
    frame(ramp, 0, 3, 1'b1);
    expOut("ramp gap", '{125, 145, 205, 225}, '{1, 1, 0, 0});
    sofChk("ramp gap", 2);

    frame(blk(300, 300, 300, 300), 0, 1, 1'b0);
    iThr_Hi = 12'd400;
    frame(blk(300, 300, 300, 300), 2, 3, 1'b0);
    expOut("midframe thr", '{300, 300, 300, 300}, '{1, 1, 1, 1});
    sofChk("midframe thr", 4);
    frame(blk(300, 300, 300, 300), 0, 3, 1'b0);
    expOut("new thr", '{300, 300, 300, 300}, '{0, 0, 0, 0});
    iThr_Hi = 12'd255;
    sofChk("new thr", 0);

    frame(blk(820, 820, 820, 820), 0, 3, 1'b0);
    frame(blk(820, 820, 820, 820), 0, 3, 1'b0);
    frame(blk(820, 820, 820, 820), 0, 1, 1'b0);
    chk("sat blocks", gq.size(), 10);
    clr();
    sofChk("saturate", 7);

    // reset lands while a completed block sits in the pipeline
    for (int x = 0; x < 4; x++) pix(x, 0, 820);
    for (int x = 0; x < 4; x++) pix(x, 1, 820);
    d0 = doneCnt;
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("midrst grey", oGrey, 0);
    chk("midrst bin", oBinary, 0);
    chk("midrst dval", oDVAL, 0);
    chk("midrst cnt", oFG_Count, 0);
    chk("midrst done", oFrame_Done, 0);
    step();
    step();
    chk("midrst no dval", oDVAL, 0);
    iSOF = 1'b1; step(); iSOF = 1'b0; step();
    chk("midrst no done", doneCnt - d0, 0);
    clr();
    frame(blk(820, 820, 820, 820), 0, 3, 1'b0);
    expOut("post rst", '{820, 820, 820, 820}, '{1, 1, 1, 1});
    sofChk("post rst", 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
